// File: rtl/allocator_pkg.sv
// Shared types and constants for the allocator header load/store unit.
package allocator_pkg;

    typedef enum logic [2:0] {
        OP_LOCK   = 3'd0,
        OP_UNLOCK = 3'd1,
        OP_LOAD   = 3'd2,
        OP_INSERT = 3'd3,
        OP_DELETE = 3'd4
    } hdr_op_e;

    typedef enum logic [2:0] {
        UOP_LD_KEY  = 3'd0,
        UOP_CAS     = 3'd1,
        UOP_ST_KEY  = 3'd2,
        UOP_LD_SIZE = 3'd3,
        UOP_LD_NEXT = 3'd4,
        UOP_ST_SIZE = 3'd5,
        UOP_ST_NEXT = 3'd6
    } uop_e;

    // Key value of an unlocked header; lock IDs must never equal it.
    localparam logic [63:0] EMPTY_KEY = 64'h0;

    localparam int unsigned DEF_KEY_OFFSET  = 0;
    localparam int unsigned DEF_SIZE_OFFSET = 8;
    localparam int unsigned DEF_NEXT_OFFSET = 16;

endpackage

// File: rtl/alloc_hdr_lsu_if.sv
// Core-side and memory-side handshakes of the header LSU.
// slave is the LSU view; master is the core plus memory environment.
interface alloc_hdr_lsu_if #(
    parameter int unsigned DATA_W = 64
);
    logic              core_req_val_i;
    logic              core_req_rdy_o;
    logic [2:0]        core_req_op_i;
    logic [DATA_W-1:0] core_req_addr_i;
    logic [DATA_W-1:0] core_req_size_i;
    logic [DATA_W-1:0] core_req_next_i;
    logic              core_rsp_val_o;
    logic              core_rsp_rdy_i;
    logic [DATA_W-1:0] core_rsp_addr_o;
    logic [DATA_W-1:0] core_rsp_size_o;
    logic [DATA_W-1:0] core_rsp_next_o;
    logic              core_rsp_err_o;
    logic              mem_req_val_o;
    logic              mem_req_rdy_i;
    logic              mem_req_is_write_o;
    logic              mem_req_is_cas_o;
    logic [DATA_W-1:0] mem_req_addr_o;
    logic [DATA_W-1:0] mem_req_data_o;
    logic [DATA_W-1:0] mem_req_cas_exp_o;
    logic              mem_rsp_val_i;
    logic              mem_rsp_rdy_o;
    logic [DATA_W-1:0] mem_rsp_data_i;

    modport slave (
        input  core_req_val_i, core_req_op_i, core_req_addr_i, core_req_size_i,
               core_req_next_i, core_rsp_rdy_i, mem_req_rdy_i, mem_rsp_val_i,
               mem_rsp_data_i,
        output core_req_rdy_o, core_rsp_val_o, core_rsp_addr_o, core_rsp_size_o,
               core_rsp_next_o, core_rsp_err_o, mem_req_val_o, mem_req_is_write_o,
               mem_req_is_cas_o, mem_req_addr_o, mem_req_data_o, mem_req_cas_exp_o,
               mem_rsp_rdy_o
    );

    modport master (
        output core_req_val_i, core_req_op_i, core_req_addr_i, core_req_size_i,
               core_req_next_i, core_rsp_rdy_i, mem_req_rdy_i, mem_rsp_val_i,
               mem_rsp_data_i,
        input  core_req_rdy_o, core_rsp_val_o, core_rsp_addr_o, core_rsp_size_o,
               core_rsp_next_o, core_rsp_err_o, mem_req_val_o, mem_req_is_write_o,
               mem_req_is_cas_o, mem_req_addr_o, mem_req_data_o, mem_req_cas_exp_o,
               mem_rsp_rdy_o
    );
endinterface

// File: rtl/alloc_lsu_backoff.sv
// Lock-retry backoff timer: start loads 2^exp_i, done_c marks the last wait cycle.
module alloc_lsu_backoff #(
    parameter int unsigned MAX_LOG2 = 5,
    localparam int unsigned EXP_W   = (MAX_LOG2 == 0) ? 1 : $clog2(MAX_LOG2 + 1),
    localparam int unsigned CNT_W   = MAX_LOG2 + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= CNT_W'(1) << exp_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alloc_hdr_lsu.sv
// Free-list header load/store unit: one header transaction at a time as single-word micro-ops.
// Optional lock-retry backoff is enabled by defining ALLOC_LSU_LOCK_BACKOFF_EN.
module alloc_hdr_lsu
    import allocator_pkg::*;
#(
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned KEY_OFFSET     = DEF_KEY_OFFSET,
    parameter int unsigned SIZE_OFFSET    = DEF_SIZE_OFFSET,
    parameter int unsigned NEXT_OFFSET    = DEF_NEXT_OFFSET,
    parameter int unsigned LOCK_ID        = 1,
    parameter int unsigned LOCK_RETRY_MAX = 16
`ifdef ALLOC_LSU_LOCK_BACKOFF_EN
   ,parameter int unsigned BACKOFF_MAX_LOG2 = 5
`endif
) (
    input logic            clk_i,
    input logic            rst_ni,
    alloc_hdr_lsu_if.slave bus
);

    localparam int unsigned RETRY_W = (LOCK_RETRY_MAX == 0) ? 1 : $clog2(LOCK_RETRY_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
`ifdef ALLOC_LSU_LOCK_BACKOFF_EN
        ST_BACKOFF,
`endif
        ST_RESP
    } state_e;

    state_e              state_q, state_d;
    uop_e                uop_q, uop_d;
    logic [DATA_W-1:0]   addr_q, size_q, next_q;
    logic [DATA_W-1:0]   rsp_size_q, rsp_size_d;
    logic [DATA_W-1:0]   rsp_next_q, rsp_next_d;
    logic                err_q, err_d;
    logic [RETRY_W-1:0]  retry_q, retry_d, retry_inc;
    logic                req_accept, lock_fail;
    logic [DATA_W-1:0]   base_c, size_c, next_c;
    logic [DATA_W-1:0]   mreq_addr_q, mreq_data_q;
    logic                mreq_wr_q, mreq_cas_q;

    function automatic logic [DATA_W-1:0] field_addr(input logic [DATA_W-1:0] base, input uop_e u);
        int unsigned off;
        case (u)
            UOP_LD_KEY, UOP_CAS, UOP_ST_KEY: off = KEY_OFFSET;
            UOP_LD_SIZE, UOP_ST_SIZE:        off = SIZE_OFFSET;
            default:                         off = NEXT_OFFSET;
        endcase
        return base + DATA_W'(off);
    endfunction

    function automatic logic [DATA_W-1:0] field_data(input uop_e u, input logic [DATA_W-1:0] sz,
                                                     input logic [DATA_W-1:0] nx);
        case (u)
            UOP_CAS:     return DATA_W'(LOCK_ID);
            UOP_ST_KEY:  return DATA_W'(EMPTY_KEY);
            UOP_ST_SIZE: return sz;
            UOP_ST_NEXT: return nx;
            default:     return '0;
        endcase
    endfunction

    // The first micro-op is launched straight from the core request fields.
    assign base_c    = (state_q == ST_IDLE) ? bus.core_req_addr_i : addr_q;
    assign size_c    = (state_q == ST_IDLE) ? bus.core_req_size_i : size_q;
    assign next_c    = (state_q == ST_IDLE) ? bus.core_req_next_i : next_q;
    assign retry_inc = retry_q + RETRY_W'(1);

`ifdef ALLOC_LSU_LOCK_BACKOFF_EN
    localparam int unsigned BO_EXP_W = (BACKOFF_MAX_LOG2 == 0) ? 1 : $clog2(BACKOFF_MAX_LOG2 + 1);
    logic                bo_start, bo_done_c;
    logic [BO_EXP_W-1:0] bo_exp;

    assign bo_exp = (32'(retry_inc) > BACKOFF_MAX_LOG2) ? BO_EXP_W'(BACKOFF_MAX_LOG2)
                                                        : BO_EXP_W'(retry_inc);

    alloc_lsu_backoff #(.MAX_LOG2(BACKOFF_MAX_LOG2)) u_backoff (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (bo_start),
        .exp_i   (bo_exp),
        .done_c  (bo_done_c)
    );
`endif

    // Next-state and micro-op sequencing.
    always_comb begin
        state_d    = state_q;
        uop_d      = uop_q;
        rsp_size_d = rsp_size_q;
        rsp_next_d = rsp_next_q;
        err_d      = err_q;
        retry_d    = retry_q;
        req_accept = 1'b0;
        lock_fail  = 1'b0;
`ifdef ALLOC_LSU_LOCK_BACKOFF_EN
        bo_start   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.core_req_val_i) begin
                    req_accept = 1'b1;
                    retry_d    = '0;
                    err_d      = 1'b0;
                    rsp_size_d = '0;
                    rsp_next_d = '0;
                    state_d    = ST_ISSUE;
                    case (bus.core_req_op_i)
                        OP_LOCK:   uop_d = UOP_LD_KEY;
                        OP_UNLOCK: uop_d = UOP_ST_KEY;
                        OP_LOAD:   uop_d = UOP_LD_SIZE;
                        OP_INSERT: uop_d = UOP_ST_SIZE;
                        OP_DELETE: uop_d = UOP_ST_NEXT;
                        default: begin
                            state_d = ST_RESP;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                if (bus.mem_req_rdy_i) state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (bus.mem_rsp_val_i) begin
                    case (uop_q)
                        UOP_LD_KEY: begin
                            if (bus.mem_rsp_data_i == DATA_W'(EMPTY_KEY)) begin
                                uop_d   = UOP_CAS;
                                state_d = ST_ISSUE;
                            end else begin
                                lock_fail = 1'b1;
                            end
                        end
                        UOP_CAS: begin
                            if (bus.mem_rsp_data_i == DATA_W'(EMPTY_KEY)) state_d = ST_RESP;
                            else                                          lock_fail = 1'b1;
                        end
                        UOP_LD_SIZE: begin
                            rsp_size_d = bus.mem_rsp_data_i;
                            uop_d      = UOP_LD_NEXT;
                            state_d    = ST_ISSUE;
                        end
                        UOP_LD_NEXT: begin
                            rsp_next_d = bus.mem_rsp_data_i;
                            state_d    = ST_RESP;
                        end
                        UOP_ST_SIZE: begin
                            uop_d   = UOP_ST_NEXT;
                            state_d = ST_ISSUE;
                        end
                        default: state_d = ST_RESP;
                    endcase
                    if (lock_fail) begin
                        retry_d = retry_inc;
                        if (LOCK_RETRY_MAX != 0 && retry_inc == RETRY_W'(LOCK_RETRY_MAX)) begin
                            state_d = ST_RESP;
                            err_d   = 1'b1;
                        end else begin
                            uop_d = UOP_LD_KEY;
`ifdef ALLOC_LSU_LOCK_BACKOFF_EN
                            bo_start = 1'b1;
                            state_d  = ST_BACKOFF;
`else
                            state_d  = ST_ISSUE;
`endif
                        end
                    end
                end
            end
`ifdef ALLOC_LSU_LOCK_BACKOFF_EN
            ST_BACKOFF: begin
                if (bo_done_c) state_d = ST_ISSUE;
            end
`endif
            ST_RESP: begin
                if (bus.core_rsp_rdy_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            uop_q      <= UOP_LD_KEY;
            addr_q     <= '0;
            size_q     <= '0;
            next_q     <= '0;
            rsp_size_q <= '0;
            rsp_next_q <= '0;
            err_q      <= 1'b0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            uop_q      <= uop_d;
            rsp_size_q <= rsp_size_d;
            rsp_next_q <= rsp_next_d;
            err_q      <= err_d;
            retry_q    <= retry_d;
            if (req_accept) begin
                addr_q <= bus.core_req_addr_i;
                size_q <= bus.core_req_size_i;
                next_q <= bus.core_req_next_i;
            end
        end
    end

    // Memory request fields are frozen on entry to ISSUE and held until the handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mreq_addr_q <= '0;
            mreq_data_q <= '0;
            mreq_wr_q   <= 1'b0;
            mreq_cas_q  <= 1'b0;
        end else if (state_d == ST_ISSUE && state_q != ST_ISSUE) begin
            mreq_addr_q <= field_addr(base_c, uop_d);
            mreq_data_q <= field_data(uop_d, size_c, next_c);
            mreq_wr_q   <= (uop_d == UOP_CAS) || (uop_d == UOP_ST_KEY) ||
                           (uop_d == UOP_ST_SIZE) || (uop_d == UOP_ST_NEXT);
            mreq_cas_q  <= (uop_d == UOP_CAS);
        end
    end

    assign bus.core_req_rdy_o     = (state_q == ST_IDLE);
    assign bus.core_rsp_val_o     = (state_q == ST_RESP);
    assign bus.core_rsp_addr_o    = addr_q;
    assign bus.core_rsp_size_o    = rsp_size_q;
    assign bus.core_rsp_next_o    = rsp_next_q;
    assign bus.core_rsp_err_o     = err_q;
    assign bus.mem_req_val_o      = (state_q == ST_ISSUE);
    assign bus.mem_req_is_write_o = mreq_wr_q;
    assign bus.mem_req_is_cas_o   = mreq_cas_q;
    assign bus.mem_req_addr_o     = mreq_addr_q;
    assign bus.mem_req_data_o     = mreq_data_q;
    assign bus.mem_req_cas_exp_o  = DATA_W'(EMPTY_KEY);
    assign bus.mem_rsp_rdy_o      = (state_q == ST_IDLE) || (state_q == ST_WAIT_RSP);

endmodule

// File: tb/tb_alloc_hdr_lsu.sv
// Directed bench for alloc_hdr_lsu with hand-computed expectations (LOCK_RETRY_MAX=3).
module tb_alloc_hdr_lsu;
    import allocator_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   t0;
    int   seen;

    alloc_hdr_lsu_if #(.DATA_W(64)) bus ();

    alloc_hdr_lsu #(
        .DATA_W         (64),
        .LOCK_RETRY_MAX (3)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (!bus.mem_req_val_o && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_req_seen"}, 64'(bus.mem_req_val_o), 64'd1);
    endtask

    // Checks one memory request, completes it with zero wait and returns rdata.
    task automatic mem_op(input string tag, input logic wr, input logic cas,
                          input logic [63:0] addr, input logic [63:0] data,
                          input logic [63:0] rdata);
        wait_mem_req(tag);
        chk({tag, "_addr"}, bus.mem_req_addr_o, addr);
        chk({tag, "_wr"}, 64'(bus.mem_req_is_write_o), 64'(wr));
        chk({tag, "_cas"}, 64'(bus.mem_req_is_cas_o), 64'(cas));
        if (wr) chk({tag, "_data"}, bus.mem_req_data_o, data);
        if (cas) chk({tag, "_exp"}, bus.mem_req_cas_exp_o, EMPTY_KEY);
        bus.mem_req_rdy_i = 1'b1;
        tick();
        chk({tag, "_no_dup"}, 64'(bus.mem_req_val_o), 64'd0);
        bus.mem_rsp_val_i  = 1'b1;
        bus.mem_rsp_data_i = rdata;
        tick();
        bus.mem_rsp_val_i  = 1'b0;
        bus.mem_rsp_data_i = '0;
    endtask

    task automatic send_req(input logic [2:0] op, input logic [63:0] addr,
                            input logic [63:0] size, input logic [63:0] next);
        int n = 0;
        bus.core_req_val_i  = 1'b1;
        bus.core_req_op_i   = op;
        bus.core_req_addr_i = addr;
        bus.core_req_size_i = size;
        bus.core_req_next_i = next;
        while (!bus.core_req_rdy_o && n < 20) begin
            tick();
            n++;
        end
        chk("req_rdy", 64'(bus.core_req_rdy_o), 64'd1);
        t0 = cyc;
        tick();
        bus.core_req_val_i = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [63:0] addr, input logic [63:0] size,
                           input logic [63:0] next, input logic err);
        int n = 0;
        while (!bus.core_rsp_val_o && n < 200) begin
            tick();
            n++;
        end
        seen = cyc;
        chk({tag, "_rsp_seen"}, 64'(bus.core_rsp_val_o), 64'd1);
        chk({tag, "_rsp_addr"}, bus.core_rsp_addr_o, addr);
        chk({tag, "_rsp_size"}, bus.core_rsp_size_o, size);
        chk({tag, "_rsp_next"}, bus.core_rsp_next_o, next);
        chk({tag, "_rsp_err"}, 64'(bus.core_rsp_err_o), 64'(err));
        bus.core_rsp_rdy_i = 1'b1;
        tick();
        bus.core_rsp_rdy_i = 1'b0;
        chk({tag, "_rsp_drop"}, 64'(bus.core_rsp_val_o), 64'd0);
        chk({tag, "_idle"}, 64'(bus.core_req_rdy_o), 64'd1);
    endtask

    initial begin
        checks              = 0;
        failures            = 0;
        cyc                 = 0;
        t0                  = 0;
        seen                = 0;
        rst_n               = 1'b0;
        bus.core_req_val_i  = 1'b0;
        bus.core_req_op_i   = '0;
        bus.core_req_addr_i = '0;
        bus.core_req_size_i = '0;
        bus.core_req_next_i = '0;
        bus.core_rsp_rdy_i  = 1'b0;
        bus.mem_req_rdy_i   = 1'b1;
        bus.mem_rsp_val_i   = 1'b0;
        bus.mem_rsp_data_i  = '0;

        // Reset state
        #1;
        chk("rst_req_rdy", 64'(bus.core_req_rdy_o), 64'd1);
        chk("rst_mem_rsp_rdy", 64'(bus.mem_rsp_rdy_o), 64'd1);
        chk("rst_mem_req_val", 64'(bus.mem_req_val_o), 64'd0);
        chk("rst_core_rsp_val", 64'(bus.core_rsp_val_o), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // LOAD with zero-wait memory: response valid 5 cycles after acceptance
        send_req(OP_LOAD, 64'h100, 64'h0, 64'h0);
        mem_op("ld_size", 1'b0, 1'b0, 64'h108, 64'h0, 64'h40);
        mem_op("ld_next", 1'b0, 1'b0, 64'h110, 64'h0, 64'h200);
        get_rsp("load", 64'h100, 64'h40, 64'h200, 1'b0);
        chk("load_latency", 64'(seen - t0), 64'd5);

        // INSERT: size then next, response fields zero
        send_req(OP_INSERT, 64'h80, 64'h20, 64'h300);
        mem_op("ins_size", 1'b1, 1'b0, 64'h88, 64'h20, 64'h0);
        mem_op("ins_next", 1'b1, 1'b0, 64'h90, 64'h300, 64'h0);
        get_rsp("insert", 64'h80, 64'h0, 64'h0, 1'b0);

        // LOCK: key busy twice, then free, CAS wins
        send_req(OP_LOCK, 64'h100, 64'h0, 64'h0);
        mem_op("lk_ld0", 1'b0, 1'b0, 64'h100, 64'h0, 64'h5);
        mem_op("lk_ld1", 1'b0, 1'b0, 64'h100, 64'h0, 64'h5);
        mem_op("lk_ld2", 1'b0, 1'b0, 64'h100, 64'h0, EMPTY_KEY);
        mem_op("lk_cas", 1'b1, 1'b1, 64'h100, 64'h1, EMPTY_KEY);
        get_rsp("lock", 64'h100, 64'h0, 64'h0, 1'b0);

        // LOCK with CAS always losing: three attempts then error
        send_req(OP_LOCK, 64'h200, 64'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            mem_op("lkf_ld", 1'b0, 1'b0, 64'h200, 64'h0, EMPTY_KEY);
            mem_op("lkf_cas", 1'b1, 1'b1, 64'h200, 64'h1, 64'h7);
        end
        chk("lkf_no_4th", 64'(bus.mem_req_val_o), 64'd0);
        get_rsp("lock_fail", 64'h200, 64'h0, 64'h0, 1'b1);

        // UNLOCK: plain store of EMPTY_KEY
        send_req(OP_UNLOCK, 64'h100, 64'h0, 64'h0);
        mem_op("unlk", 1'b1, 1'b0, 64'h100, EMPTY_KEY, 64'h0);
        get_rsp("unlock", 64'h100, 64'h0, 64'h0, 1'b0);

        // Illegal op: straight to response, no memory access
        send_req(3'd7, 64'h55, 64'h0, 64'h0);
        chk("ill_no_mem", 64'(bus.mem_req_val_o), 64'd0);
        chk("ill_rsp_now", 64'(bus.core_rsp_val_o), 64'd1);
        get_rsp("illegal", 64'h55, 64'h0, 64'h0, 1'b1);

        // Address wrap past the top of the address space
        send_req(OP_LOAD, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0);
        mem_op("wrap_size", 1'b0, 1'b0, 64'h0, 64'h0, 64'h33);
        mem_op("wrap_next", 1'b0, 1'b0, 64'h8, 64'h0, 64'h44);
        get_rsp("wrap", 64'hFFFF_FFFF_FFFF_FFF8, 64'h33, 64'h44, 1'b0);

        // Backpressure on both the memory request and the core response
        bus.mem_req_rdy_i = 1'b0;
        send_req(OP_LOAD, 64'h300, 64'h0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_req_val", 64'(bus.mem_req_val_o), 64'd1);
            chk("bp_req_addr", bus.mem_req_addr_o, 64'h308);
            tick();
        end
        mem_op("bp_size", 1'b0, 1'b0, 64'h308, 64'h0, 64'h11);
        mem_op("bp_next", 1'b0, 1'b0, 64'h310, 64'h0, 64'h22);
        for (int i = 0; i < 3; i++) begin
            chk("bp_rsp_val", 64'(bus.core_rsp_val_o), 64'd1);
            chk("bp_rsp_size", bus.core_rsp_size_o, 64'h11);
            chk("bp_rsp_next", bus.core_rsp_next_o, 64'h22);
            chk("bp_req_rdy_low", 64'(bus.core_req_rdy_o), 64'd0);
            tick();
        end
        get_rsp("bp", 64'h300, 64'h11, 64'h22, 1'b0);

        // Reset while DELETE waits for its store response
        send_req(OP_DELETE, 64'h400, 64'h0, 64'h500);
        wait_mem_req("del");
        chk("del_addr", bus.mem_req_addr_o, 64'h410);
        chk("del_data", bus.mem_req_data_o, 64'h500);
        chk("del_wr", 64'(bus.mem_req_is_write_o), 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_val", 64'(bus.mem_req_val_o), 64'd0);
        chk("mid_rst_mem_addr", bus.mem_req_addr_o, 64'h0);
        chk("mid_rst_mem_data", bus.mem_req_data_o, 64'h0);
        chk("mid_rst_mem_wr", 64'(bus.mem_req_is_write_o), 64'd0);
        chk("mid_rst_rsp_val", 64'(bus.core_rsp_val_o), 64'd0);
        chk("mid_rst_rsp_addr", bus.core_rsp_addr_o, 64'h0);
        chk("mid_rst_req_rdy", 64'(bus.core_req_rdy_o), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        bus.mem_rsp_val_i  = 1'b1;
        bus.mem_rsp_data_i = 64'hDEAD;
        chk("stray_rsp_rdy", 64'(bus.mem_rsp_rdy_o), 64'd1);
        tick();
        bus.mem_rsp_val_i  = 1'b0;
        bus.mem_rsp_data_i = '0;
        chk("stray_no_req", 64'(bus.mem_req_val_o), 64'd0);
        chk("stray_no_rsp", 64'(bus.core_rsp_val_o), 64'd0);
        chk("stray_idle", 64'(bus.core_req_rdy_o), 64'd1);
        send_req(OP_LOAD, 64'h100, 64'h0, 64'h0);
        mem_op("post_size", 1'b0, 1'b0, 64'h108, 64'h0, 64'h77);
        mem_op("post_next", 1'b0, 1'b0, 64'h110, 64'h0, 64'h88);
        get_rsp("post_rst", 64'h100, 64'h77, 64'h88, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
